// File: rtl/inst_fetch_unit_pkg.sv
// Shared types, default address map and helpers for the instruction fetch unit.
package inst_fetch_unit_pkg;

  // Default address map of the text segment.
  localparam logic [31:0] DEF_RESET_PC   = 32'h0040_0000;
  localparam logic [31:0] DEF_TEXT_BASE  = 32'h0040_0000;
  localparam logic [31:0] DEF_TEXT_LIMIT = 32'h0040_1000;

  // Size of one instruction word in bytes.
  localparam logic [31:0] INSTR_BYTES = 32'd4;

  // Fetch controller states.
  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_FAULT = 1'b1
  } fetch_state_e;

  // One buffered fetch: the address it came from and the word read there.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // An address cannot be fetched if it is not word aligned or lies outside [base, limit).
  function automatic logic addr_is_bad(
    input logic [31:0] addr,
    input logic [31:0] base,
    input logic [31:0] limit
  );
    logic misaligned;
    logic below;
    logic above;
    misaligned = (addr[1:0] != 2'b00);
    below      = (addr < base);
    above      = (addr >= limit);
    return misaligned | below | above;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_skid_fifo.sv
// Two-entry FIFO of {pc, instr} pairs sitting between the memory port and decode.
// The head is always slot0, so the decode-facing outputs come straight from a register.
module inst_fetch_unit_skid_fifo
  import inst_fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t push_data,
  output fetch_entry_t head,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t slot0_r;
  fetch_entry_t slot1_r;
  fetch_entry_t slot0_nxt_s;
  fetch_entry_t slot1_nxt_s;
  logic [1:0]   count_r;
  logic [1:0]   count_nxt_s;
  logic         pop_ok_s;
  logic         push_ok_s;

  // Qualify requests: pop needs data, push needs room (a same-edge pop makes room).
  always_comb begin
    pop_ok_s  = pop && (count_r != 2'd0);
    push_ok_s = push && ((count_r != 2'd2) || pop_ok_s);
  end

  // Next slot contents and occupancy; flush discards everything including a same-edge pop.
  always_comb begin
    slot0_nxt_s = slot0_r;
    slot1_nxt_s = slot1_r;
    count_nxt_s = count_r;
    if (flush) begin
      count_nxt_s = 2'd0;
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            slot0_nxt_s = push_data;
          end else begin
            slot1_nxt_s = push_data;
          end
          count_nxt_s = count_r + 2'd1;
        end
        2'b01: begin
          slot0_nxt_s = slot1_r;
          count_nxt_s = count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            slot0_nxt_s = push_data;
          end else begin
            slot0_nxt_s = slot1_r;
            slot1_nxt_s = push_data;
          end
          count_nxt_s = count_r;
        end
        default: begin
          count_nxt_s = count_r;
        end
      endcase
    end
  end

  // Slot and occupancy registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot0_r <= '0;
      slot1_r <= '0;
      count_r <= 2'd0;
    end else begin
      slot0_r <= slot0_nxt_s;
      slot1_r <= slot1_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  assign head  = slot0_r;
  assign count = count_r;
  assign full  = (count_r == 2'd2);
  assign empty = (count_r == 2'd0);

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the instruction memory port, buffers
// fetched words for decode and raises a fault on misaligned or out-of-text addresses.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] TEXT_BASE  = DEF_TEXT_BASE,
  parameter logic [31:0] TEXT_LIMIT = DEF_TEXT_LIMIT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_cs,
  output logic        mem_oe,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [31:0] fault_pc
);

  logic [31:0]  pc_r;
  logic [31:0]  pc_nxt_s;
  fetch_state_e state_r;
  fetch_state_e state_nxt_s;

  logic         pc_bad_s;
  logic         issue_s;
  logic         pop_s;
  fetch_entry_t push_data_s;
  fetch_entry_t head_s;
  logic [1:0]   fifo_count_s;
  logic         fifo_full_s;
  logic         fifo_empty_s;

  // Range/alignment check of the current fetch address and the fetch/pop decisions.
  always_comb begin
    pc_bad_s = addr_is_bad(pc_r, TEXT_BASE, TEXT_LIMIT);
    issue_s  = (state_r == ST_FETCH) && !pc_bad_s && !fifo_full_s
               && !redirect_valid && !rst;
    pop_s    = !fifo_empty_s && out_ready;
    push_data_s.pc    = pc_r;
    push_data_s.instr = mem_dout;
  end

  // Next PC and FSM state: redirect wins, otherwise advance on issue or trap on a bad PC.
  always_comb begin
    pc_nxt_s    = pc_r;
    state_nxt_s = state_r;
    if (redirect_valid) begin
      pc_nxt_s    = redirect_pc;
      state_nxt_s = ST_FETCH;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (pc_bad_s) begin
            state_nxt_s = ST_FAULT;
          end else if (issue_s) begin
            pc_nxt_s = pc_r + INSTR_BYTES;
          end else begin
            pc_nxt_s = pc_r;
          end
        end
        ST_FAULT: begin
          state_nxt_s = ST_FAULT;
        end
        default: begin
          state_nxt_s = ST_FETCH;
        end
      endcase
    end
  end

  // PC and state registers; reset overrides redirect and handshake inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r    <= RESET_PC;
      state_r <= ST_FETCH;
    end else begin
      pc_r    <= pc_nxt_s;
      state_r <= state_nxt_s;
    end
  end

  inst_fetch_unit_skid_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (issue_s),
    .pop       (pop_s),
    .push_data (push_data_s),
    .head      (head_s),
    .count     (fifo_count_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  assign mem_cs    = issue_s;
  assign mem_oe    = issue_s;
  assign mem_we    = 1'b0;
  assign mem_addr  = pc_r;
  assign mem_din   = 32'h0000_0000;

  assign out_valid = !fifo_empty_s;
  assign out_instr = head_s.instr;
  assign out_pc    = head_s.pc;

  // The fault is only reported once every word fetched before it has been delivered.
  assign fault     = (state_r == ST_FAULT) && (fifo_count_s == 2'd0);
  assign fault_pc  = pc_r;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios followed by random
// redirects, resets and back-pressure, compared against a queue-based reference model.
module tb_inst_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0040_0000;
  localparam logic [31:0] TEXT_BASE  = 32'h0040_0000;
  localparam logic [31:0] TEXT_LIMIT = 32'h0040_1000;

  logic        clk;
  logic        rst;
  logic        mem_cs;
  logic        mem_oe;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic [31:0] fault_pc;

  int n_checks;
  int n_errors;

  // Reference model state: architectural PC, fault mode and the words awaiting decode.
  logic [31:0] m_pc;
  logic        m_fault;
  logic [63:0] m_q[$];

  inst_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .mem_cs         (mem_cs),
    .mem_oe         (mem_oe),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory stand-in: a distinct, address-derived word at every location.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h1357, a[31:16]} + 32'h0BAD_F00D;
  endfunction

  assign mem_dout = mem_word(mem_addr);

  function automatic logic ref_bad(input logic [31:0] a);
    return ((a % 32'd4) != 32'd0) || (a < TEXT_BASE) || (a >= TEXT_LIMIT);
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = RESET_PC;
    m_fault = 1'b0;
    m_q.delete();
  endtask

  // One clock cycle: apply inputs, compare outputs to the model, advance the model past the edge.
  task automatic step(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    logic exp_cs;
    logic exp_fault;
    logic [63:0] head;
    @(negedge clk);
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    #1;
    exp_cs    = !r && !rv && !m_fault && !ref_bad(m_pc) && (m_q.size() < 2);
    exp_fault = m_fault && (m_q.size() == 0);
    check_eq("mem_cs", {63'd0, mem_cs}, {63'd0, exp_cs});
    check_eq("mem_oe", {63'd0, mem_oe}, {63'd0, exp_cs});
    check_eq("mem_we", {63'd0, mem_we}, 64'd0);
    check_eq("mem_din", {32'd0, mem_din}, 64'd0);
    check_eq("mem_addr", {32'd0, mem_addr}, {32'd0, m_pc});
    check_eq("out_valid", {63'd0, out_valid}, {63'd0, (m_q.size() != 0)});
    if (m_q.size() != 0) begin
      head = m_q[0];
      check_eq("out_pc", {32'd0, out_pc}, {32'd0, head[63:32]});
      check_eq("out_instr", {32'd0, out_instr}, {32'd0, head[31:0]});
    end
    check_eq("fault", {63'd0, fault}, {63'd0, exp_fault});
    if (exp_fault) begin
      check_eq("fault_pc", {32'd0, fault_pc}, {32'd0, m_pc});
    end
    if (r) begin
      model_reset();
    end else if (rv) begin
      m_q.delete();
      m_pc    = rpc;
      m_fault = 1'b0;
    end else begin
      if ((m_q.size() != 0) && rdy) begin
        void'(m_q.pop_front());
      end
      if (exp_cs) begin
        m_q.push_back({m_pc, mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end else if (!m_fault && ref_bad(m_pc)) begin
        m_fault = 1'b1;
      end
    end
  endtask

  task automatic run(input int n, input logic rdy);
    for (int k = 0; k < n; k++) begin
      step(1'b0, 1'b0, 32'd0, rdy);
    end
  endtask

  function automatic logic [31:0] pick_target();
    int unsigned sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0:       return TEXT_LIMIT - 32'd4;
      1:       return TEXT_LIMIT - 32'd8;
      2:       return TEXT_BASE - 32'd4;
      3:       return 32'hFFFF_FFFC;
      4:       return TEXT_BASE + 32'($urandom_range(0, 4095));
      5:       return $urandom;
      default: return TEXT_BASE + 32'd4 * 32'($urandom_range(0, 1023));
    endcase
  endfunction

  // Stimulus: reset, directed scenarios, then a randomized soak.
  initial begin
    logic r;
    logic rv;
    logic rdy;
    n_checks       = 0;
    n_errors       = 0;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    out_ready      = 1'b0;
    model_reset();
    @(posedge clk);
    step(1'b1, 1'b0, 32'd0, 1'b0);

    // Streaming, then back-pressure and release.
    run(8, 1'b1);
    run(5, 1'b0);
    run(4, 1'b1);

    // Redirect while the buffer is full, with decode ready in the same cycle.
    run(3, 1'b0);
    step(1'b0, 1'b1, 32'h0040_0050, 1'b1);
    run(4, 1'b1);

    // Misaligned redirect faults; a good redirect recovers.
    step(1'b0, 1'b1, 32'h0040_0052, 1'b1);
    run(4, 1'b1);
    step(1'b0, 1'b1, 32'h0040_003C, 1'b1);
    run(3, 1'b1);

    // Last legal word, then fault at the limit; reset mid-stream overrides a redirect.
    step(1'b0, 1'b1, TEXT_LIMIT - 32'd4, 1'b1);
    run(5, 1'b1);
    step(1'b0, 1'b1, 32'h0040_0100, 1'b1);
    run(2, 1'b0);
    step(1'b1, 1'b1, 32'h0040_0200, 1'b1);
    run(3, 1'b1);

    // Randomized soak with phases of heavier back-pressure.
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 199) == 0);
      rv  = ($urandom_range(0, 15) == 0);
      if (i[8]) begin
        rdy = ($urandom_range(0, 3) == 0);
      end else begin
        rdy = ($urandom_range(0, 3) != 0);
      end
      step(r, rv, pick_target(), rdy);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
